// File: rtl/fetch_core.sv
// rv32i fetch front end: PC, one AXI4-Lite AR/R read per instruction, debug handshake port.
// 3 cycles/instruction with zero-wait memory; stalls in ADDR/DATA/DBG until the matching ready/valid.
module fetch_core #(
  parameter int XLEN      = 32,
  parameter int IMADDRLEN = 32,
  parameter int IMDATALEN = XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rstn,
  output logic                 im_arvalid,
  input  logic                 im_arready,
  output logic [IMADDRLEN-1:0] im_araddr,
  input  logic                 im_rvalid,
  output logic                 im_rready,
  input  logic [IMDATALEN-1:0] im_rdata,
  output logic                 o_dbg_state_valid,
  input  logic                 i_dbg_state_ready,
  output logic [1:0]           o_dbg_state_data,
  output logic [IMDATALEN-1:0] o_dbg_instr_data,
  input  logic [XLEN-1:0]      i_dbg_imm_data,
  output logic [XLEN-1:0]      o_dbg_pc_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DBG  = 2'd3
  } state_e;

  state_e                 state;
  logic [XLEN-1:0]        pc;
  logic [IMDATALEN-1:0]   instr;
  logic                   arvalid;
  logic                   rready;
  logic                   dbg_valid;

  // rstn is active-high despite its name; reset also drops rready so a pending R beat is lost
  always_ff @(posedge clk) begin
    if (rstn) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      instr     <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      dbg_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          arvalid <= 1'b1;
          state   <= ADDR;
        end
        ADDR: begin
          if (arvalid && im_arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= DATA;
          end
        end
        DATA: begin
          if (rready && im_rvalid) begin
            instr     <= im_rdata;
            rready    <= 1'b0;
            dbg_valid <= 1'b1;
            state     <= DBG;
          end
        end
        DBG: begin
          if (dbg_valid && i_dbg_state_ready) begin
            pc        <= pc + i_dbg_imm_data;
            dbg_valid <= 1'b0;
            arvalid   <= 1'b1;
            state     <= ADDR;
          end
        end
        default: begin
          arvalid   <= 1'b0;
          rready    <= 1'b0;
          dbg_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign im_arvalid        = arvalid;
  assign im_araddr         = pc[IMADDRLEN-1:0];
  assign im_rready         = rready;
  assign o_dbg_state_valid = dbg_valid;
  assign o_dbg_state_data  = state;
  assign o_dbg_instr_data  = instr;
  assign o_dbg_pc_data     = pc;

endmodule

// File: tb/tb_fetch_core.sv
// Bench for fetch_core: table of fetch iterations plus reset sequences; scoreboard checks each debug record.
module tb_fetch_core;

  logic        clk = 1'b0;
  logic        rstn;
  logic        im_arvalid;
  logic        im_arready;
  logic [31:0] im_araddr;
  logic        im_rvalid;
  logic        im_rready;
  logic [31:0] im_rdata;
  logic        o_dbg_state_valid;
  logic        i_dbg_state_ready;
  logic [1:0]  o_dbg_state_data;
  logic [31:0] o_dbg_instr_data;
  logic [31:0] i_dbg_imm_data;
  logic [31:0] o_dbg_pc_data;

  fetch_core dut (
    .clk               (clk),
    .rstn              (rstn),
    .im_arvalid        (im_arvalid),
    .im_arready        (im_arready),
    .im_araddr         (im_araddr),
    .im_rvalid         (im_rvalid),
    .im_rready         (im_rready),
    .im_rdata          (im_rdata),
    .o_dbg_state_valid (o_dbg_state_valid),
    .i_dbg_state_ready (i_dbg_state_ready),
    .o_dbg_state_data  (o_dbg_state_data),
    .o_dbg_instr_data  (o_dbg_instr_data),
    .i_dbg_imm_data    (i_dbg_imm_data),
    .o_dbg_pc_data     (o_dbg_pc_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          ar_wait;
    int          r_wait;
    logic        early_r;
    logic [31:0] rdata;
    int          dbg_wait;
    logic [31:0] imm;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } rec_t;

  rec_t sb_q[$];
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each new debug record must match the oldest accepted R beat and its fetch PC
  always @(posedge clk) begin
    #2;
    if (o_dbg_state_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_record", 64'd1, 64'd0);
      end else begin
        rec_t r;
        r = sb_q.pop_front();
        check("sb_pc", {32'd0, o_dbg_pc_data}, {32'd0, r.pc});
        check("sb_instr", {32'd0, o_dbg_instr_data}, {32'd0, r.instr});
      end
    end
    prev_valid = o_dbg_state_valid;
  end

  // One full ADDR -> DATA -> DBG -> ADDR iteration; entered and left with the DUT in ADDR
  task automatic run_vec(input vec_t v);
    int cyc;
    cyc = 0;
    check("addr_entry", {29'd0, im_arvalid, im_rready, o_dbg_state_valid, 30'd0, o_dbg_state_data},
          {29'd0, 1'b1, 1'b0, 1'b0, 30'd0, 2'd1});
    check("araddr", {32'd0, im_araddr}, {32'd0, v.exp_addr});
    im_arready = 1'b0;
    for (int i = 0; i < v.ar_wait; i++) begin
      tick(); cyc++;
      check("ar_stall_stable", {31'd0, im_arvalid, im_araddr}, {31'd0, 1'b1, v.exp_addr});
    end
    im_arready = 1'b1;
    if (v.early_r) begin
      im_rvalid = 1'b1;
      im_rdata  = 32'hBAD0_BAD0;
    end
    tick(); cyc++;
    im_arready = 1'b0;
    im_rvalid  = 1'b0;
    check("data_entry", {29'd0, im_arvalid, im_rready, o_dbg_state_valid, 30'd0, o_dbg_state_data},
          {29'd0, 1'b0, 1'b1, 1'b0, 30'd0, 2'd2});
    for (int i = 0; i < v.r_wait; i++) begin
      tick(); cyc++;
      check("r_wait_state", {62'd0, o_dbg_state_data}, {62'd0, 2'd2});
    end
    im_rvalid = 1'b1;
    im_rdata  = v.rdata;
    sb_q.push_back('{pc: v.exp_addr, instr: v.rdata});
    tick(); cyc++;
    im_rvalid = 1'b0;
    check("dbg_entry", {29'd0, im_arvalid, im_rready, o_dbg_state_valid, 30'd0, o_dbg_state_data},
          {29'd0, 1'b0, 1'b0, 1'b1, 30'd0, 2'd3});
    for (int i = 0; i < v.dbg_wait; i++) begin
      tick(); cyc++;
      check("dbg_stall_stable", {o_dbg_state_valid, o_dbg_state_data, o_dbg_instr_data[28:0], o_dbg_pc_data},
            {1'b1, 2'd3, v.rdata[28:0], v.exp_addr});
    end
    i_dbg_state_ready = 1'b1;
    i_dbg_imm_data    = v.imm;
    tick(); cyc++;
    i_dbg_state_ready = 1'b0;
    i_dbg_imm_data    = 32'd0;
    check("next_araddr", {31'd0, im_arvalid, im_araddr}, {31'd0, 1'b1, v.exp_next});
    check("next_state", {62'd0, o_dbg_state_data}, {62'd0, 2'd1});
    check("iter_cycles", 64'(cyc), 64'(3 + v.ar_wait + v.r_wait + v.dbg_wait));
  endtask

  vec_t vecs[6];
  vec_t post;

  initial begin
    vecs[0] = '{ar_wait: 4, r_wait: 0, early_r: 1'b0, rdata: 32'h0050_0093, dbg_wait: 0,
                imm: 32'h0000_0004, exp_addr: 32'h0000_0000, exp_next: 32'h0000_0004};
    vecs[1] = '{ar_wait: 0, r_wait: 2, early_r: 1'b0, rdata: 32'h00A0_0113, dbg_wait: 5,
                imm: 32'hFFFF_FFFC, exp_addr: 32'h0000_0004, exp_next: 32'h0000_0000};
    vecs[2] = '{ar_wait: 0, r_wait: 0, early_r: 1'b0, rdata: 32'h0020_81B3, dbg_wait: 0,
                imm: 32'hFFFF_FFFC, exp_addr: 32'h0000_0000, exp_next: 32'hFFFF_FFFC};
    vecs[3] = '{ar_wait: 1, r_wait: 1, early_r: 1'b1, rdata: 32'hDEAD_BEEF, dbg_wait: 2,
                imm: 32'h0000_0008, exp_addr: 32'hFFFF_FFFC, exp_next: 32'h0000_0004};
    vecs[4] = '{ar_wait: 0, r_wait: 0, early_r: 1'b0, rdata: 32'h1234_5678, dbg_wait: 0,
                imm: 32'h0000_0002, exp_addr: 32'h0000_0004, exp_next: 32'h0000_0006};
    vecs[5] = '{ar_wait: 2, r_wait: 0, early_r: 1'b1, rdata: 32'hFFFF_F0B7, dbg_wait: 1,
                imm: 32'h8000_0000, exp_addr: 32'h0000_0006, exp_next: 32'h8000_0006};
    post    = '{ar_wait: 0, r_wait: 0, early_r: 1'b0, rdata: 32'h0000_0013, dbg_wait: 0,
                imm: 32'h0000_0004, exp_addr: 32'h0000_0000, exp_next: 32'h0000_0004};

    rstn = 1'b1;
    im_arready = 1'b0;
    im_rvalid = 1'b0;
    im_rdata = 32'd0;
    i_dbg_state_ready = 1'b0;
    i_dbg_imm_data = 32'd0;

    repeat (3) tick();
    check("reset_ctrl", {61'd0, im_arvalid, im_rready, o_dbg_state_valid}, 64'd0);
    check("reset_state", {62'd0, o_dbg_state_data}, 64'd0);
    check("reset_pc_instr", {o_dbg_pc_data, o_dbg_instr_data}, 64'd0);
    rstn = 1'b0;
    check("idle_after_release", {61'd0, im_arvalid, o_dbg_state_data}, 64'd0);
    tick();
    check("first_ar", {31'd0, im_arvalid, im_araddr}, {31'd0, 1'b1, 32'h0});

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in DATA with an R beat pending: it must be dropped, not latched
    im_arready = 1'b1;
    tick();
    im_arready = 1'b0;
    check("pre_reset_data", {62'd0, o_dbg_state_data}, {62'd0, 2'd2});
    im_rvalid = 1'b1;
    im_rdata  = 32'hCAFE_F00D;
    rstn      = 1'b1;
    tick();
    check("rst_mid_rready", {63'd0, im_rready}, 64'd0);
    check("rst_mid_state", {62'd0, o_dbg_state_data}, 64'd0);
    check("rst_mid_pc_instr", {o_dbg_pc_data, o_dbg_instr_data}, 64'd0);
    rstn = 1'b0;
    tick();
    tick();
    check("rst_pending_ignored", {59'd0, im_rready, o_dbg_state_valid, im_arvalid, o_dbg_state_data},
          {59'd0, 1'b0, 1'b0, 1'b1, 2'd1});
    check("rst_araddr", {32'd0, im_araddr}, 64'd0);
    im_rvalid = 1'b0;
    run_vec(post);

    tick();
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
